asm_encoder: RTL and testbench

//  Mini-assembler: turns one {mnemonic, addressing mode, operand, width flags} request

---
 rtl/asm_pkg.sv | 46 ++++
 rtl/asm_opcode_lut.sv | 180 ++++++++++++++++++
 rtl/asm_encoder.sv | 127 ++++++++++++
 tb/tb_asm_encoder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/asm_pkg.sv
// Shared types and helpers for the 65C2424 mini-assembler.
// Addressing modes, encoder FSM states, prefix and operand-length helpers.
package asm_pkg;

    typedef enum logic [3:0] {
        IMP, ACC, IMM, ZP, ZPX, ZPY, ABS, ABX,
        ABY, IND, INX, INY, ZPI, REL, AIX
    } mode_t;

    typedef enum logic [2:0] {
        IDLE, PFX, OPC, OP0, OP1, OP2
    } state_t;

    localparam logic [3:0] PFX_BASE = 4'hF;

    // Operand bytes following the opcode.
    function automatic logic [1:0] op_len(
        input logic [3:0] m,
        input logic [1:0] rw,
        input logic       aw24
    );
        logic [1:0] n;
        n = 2'd0;
        case (m)
            IMP, ACC:
                n = 2'd0;
            IMM:
                n = 2'd1 + rw;
            ZP, ZPX, ZPY, INX, INY, ZPI, REL:
                n = 2'd1;
            ABS, ABX, ABY, IND, AIX:
                n = 2'd2 + {1'b0, aw24};
            default:
                n = 2'd0;
        endcase
        return n;
    endfunction

    function automatic logic [7:0] prefix_byte(
        input logic [1:0] rw,
        input logic       aw24
    );
        return {rw == 2'd2, rw == 2'd1, 1'b0, aw24, PFX_BASE};
    endfunction

endpackage

// File: rtl/asm_opcode_lut.sv
// Combinational {mnemonic, mode} -> opcode lookup for the 65C02 set plus
// the CPU prefix codes. Ports: mnem, mode in; opcode, valid out.
import asm_pkg::*;

module asm_opcode_lut (
    input  logic [23:0] mnem,
    input  logic [3:0]  mode,
    output logic [7:0]  opcode,
    output logic        valid
);

    logic       g1;
    logic       g2;
    logic [2:0] aaa;
    logic [4:0] lo;
    logic       lo_ok;
    logic [8:0] r;

    always_comb begin
        g1  = 1'b0;
        g2  = 1'b0;
        aaa = 3'd0;
        case (mnem)
            "ORA": begin g1 = 1'b1; aaa = 3'd0; end
            "AND": begin g1 = 1'b1; aaa = 3'd1; end
            "EOR": begin g1 = 1'b1; aaa = 3'd2; end
            "ADC": begin g1 = 1'b1; aaa = 3'd3; end
            "STA": begin g1 = 1'b1; aaa = 3'd4; end
            "LDA": begin g1 = 1'b1; aaa = 3'd5; end
            "CMP": begin g1 = 1'b1; aaa = 3'd6; end
            "SBC": begin g1 = 1'b1; aaa = 3'd7; end
            "ASL": begin g2 = 1'b1; aaa = 3'd0; end
            "ROL": begin g2 = 1'b1; aaa = 3'd1; end
            "LSR": begin g2 = 1'b1; aaa = 3'd2; end
            "ROR": begin g2 = 1'b1; aaa = 3'd3; end
            default: ;
        endcase
    end

    // Regular ALU and shift groups: opcode = {aaa, mode column}.
    always_comb begin
        lo    = 5'd0;
        lo_ok = 1'b0;
        if (g1) begin
            lo_ok = 1'b1;
            case (mode)
                INX:     lo = 5'h01;
                ZP:      lo = 5'h05;
                IMM:     lo = 5'h09;
                ABS:     lo = 5'h0D;
                INY:     lo = 5'h11;
                ZPI:     lo = 5'h12;
                ZPX:     lo = 5'h15;
                ABY:     lo = 5'h19;
                ABX:     lo = 5'h1D;
                default: lo_ok = 1'b0;
            endcase
            // 0x89 is BIT #imm, there is no STA #imm.
            if (mnem == "STA" && mode == IMM)
                lo_ok = 1'b0;
        end else if (g2) begin
            lo_ok = 1'b1;
            case (mode)
                ZP:      lo = 5'h06;
                ACC:     lo = 5'h0A;
                ABS:     lo = 5'h0E;
                ZPX:     lo = 5'h16;
                ABX:     lo = 5'h1E;
                default: lo_ok = 1'b0;
            endcase
        end
    end

    always_comb begin
        r = 9'h000;
        if (lo_ok) begin
            r = {1'b1, aaa, lo};
        end else begin
            case ({mnem, mode})
                {"INC", ACC}: r = 9'h11A;
                {"INC", ZP }: r = 9'h1E6;
                {"INC", ZPX}: r = 9'h1F6;
                {"INC", ABS}: r = 9'h1EE;
                {"INC", ABX}: r = 9'h1FE;
                {"DEC", ACC}: r = 9'h13A;
                {"DEC", ZP }: r = 9'h1C6;
                {"DEC", ZPX}: r = 9'h1D6;
                {"DEC", ABS}: r = 9'h1CE;
                {"DEC", ABX}: r = 9'h1DE;
                {"LDX", IMM}: r = 9'h1A2;
                {"LDX", ZP }: r = 9'h1A6;
                {"LDX", ZPY}: r = 9'h1B6;
                {"LDX", ABS}: r = 9'h1AE;
                {"LDX", ABY}: r = 9'h1BE;
                {"STX", ZP }: r = 9'h186;
                {"STX", ZPY}: r = 9'h196;
                {"STX", ABS}: r = 9'h18E;
                {"LDY", IMM}: r = 9'h1A0;
                {"LDY", ZP }: r = 9'h1A4;
                {"LDY", ZPX}: r = 9'h1B4;
                {"LDY", ABS}: r = 9'h1AC;
                {"LDY", ABX}: r = 9'h1BC;
                {"STY", ZP }: r = 9'h184;
                {"STY", ZPX}: r = 9'h194;
                {"STY", ABS}: r = 9'h18C;
                {"CPX", IMM}: r = 9'h1E0;
                {"CPX", ZP }: r = 9'h1E4;
                {"CPX", ABS}: r = 9'h1EC;
                {"CPY", IMM}: r = 9'h1C0;
                {"CPY", ZP }: r = 9'h1C4;
                {"CPY", ABS}: r = 9'h1CC;
                {"BIT", IMM}: r = 9'h189;
                {"BIT", ZP }: r = 9'h124;
                {"BIT", ZPX}: r = 9'h134;
                {"BIT", ABS}: r = 9'h12C;
                {"BIT", ABX}: r = 9'h13C;
                {"STZ", ZP }: r = 9'h164;
                {"STZ", ZPX}: r = 9'h174;
                {"STZ", ABS}: r = 9'h19C;
                {"STZ", ABX}: r = 9'h19E;
                {"TSB", ZP }: r = 9'h104;
                {"TSB", ABS}: r = 9'h10C;
                {"TRB", ZP }: r = 9'h114;
                {"TRB", ABS}: r = 9'h11C;
                {"JMP", ABS}: r = 9'h14C;
                {"JMP", IND}: r = 9'h16C;
                {"JMP", AIX}: r = 9'h17C;
                {"JSR", ABS}: r = 9'h120;
                {"BPL", REL}: r = 9'h110;
                {"BMI", REL}: r = 9'h130;
                {"BVC", REL}: r = 9'h150;
                {"BVS", REL}: r = 9'h170;
                {"BRA", REL}: r = 9'h180;
                {"BCC", REL}: r = 9'h190;
                {"BCS", REL}: r = 9'h1B0;
                {"BNE", REL}: r = 9'h1D0;
                {"BEQ", REL}: r = 9'h1F0;
                {"BRK", IMP}: r = 9'h100;
                {"PHP", IMP}: r = 9'h108;
                {"CLC", IMP}: r = 9'h118;
                {"PLP", IMP}: r = 9'h128;
                {"SEC", IMP}: r = 9'h138;
                {"RTI", IMP}: r = 9'h140;
                {"PHA", IMP}: r = 9'h148;
                {"CLI", IMP}: r = 9'h158;
                {"PHY", IMP}: r = 9'h15A;
                {"RTS", IMP}: r = 9'h160;
                {"PLA", IMP}: r = 9'h168;
                {"SEI", IMP}: r = 9'h178;
                {"PLY", IMP}: r = 9'h17A;
                {"DEY", IMP}: r = 9'h188;
                {"TXA", IMP}: r = 9'h18A;
                {"TYA", IMP}: r = 9'h198;
                {"TXS", IMP}: r = 9'h19A;
                {"TAY", IMP}: r = 9'h1A8;
                {"TAX", IMP}: r = 9'h1AA;
                {"CLV", IMP}: r = 9'h1B8;
                {"TSX", IMP}: r = 9'h1BA;
                {"INY", IMP}: r = 9'h1C8;
                {"DEX", IMP}: r = 9'h1CA;
                {"WAI", IMP}: r = 9'h1CB;
                {"CLD", IMP}: r = 9'h1D8;
                {"PHX", IMP}: r = 9'h1DA;
                {"STP", IMP}: r = 9'h1DB;
                {"INX", IMP}: r = 9'h1E8;
                {"NOP", IMP}: r = 9'h1EA;
                {"SED", IMP}: r = 9'h1F8;
                {"PLX", IMP}: r = 9'h1FA;
                {"A24", IMP}: r = 9'h11F;
                {"R16", IMP}: r = 9'h14F;
                {"R24", IMP}: r = 9'h18F;
                default:      r = 9'h000;
            endcase
        end
    end

    assign opcode = r[7:0];
    assign valid  = r[8];

endmodule

// File: rtl/asm_encoder.sv
// Mini-assembler: one request in, prefix/opcode/operand bytes out.
// Ports: in_valid/in_ready request, out_valid/out_ready byte stream, err.
import asm_pkg::*;

module asm_encoder #(
    parameter bit ALLOW_PREFIX = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] mnem,
    input  logic [3:0]  mode,
    input  logic [23:0] operand,
    input  logic        aw24,
    input  logic [1:0]  rw,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_byte,
    output logic        out_last,
    output logic        err
);

    logic [7:0]  lut_op;
    logic        lut_ok;
    logic        need_pfx;
    logic        bad;
    logic        accept;
    logic        fire;
    logic [1:0]  len;

    state_t      state;
    logic [7:0]  opc_q;
    logic [23:0] opnd_q;
    logic [1:0]  n_q;

    asm_opcode_lut u_lut (
        .mnem   (mnem),
        .mode   (mode),
        .opcode (lut_op),
        .valid  (lut_ok)
    );

    assign need_pfx = aw24 || (rw != 2'd0);
    assign bad      = !lut_ok || (rw == 2'd3) ||
                      (need_pfx && !ALLOW_PREFIX);
    assign accept   = in_valid && in_ready;
    assign fire     = out_valid && out_ready;
    assign len      = op_len(mode, rw, aw24);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_byte  <= 8'h00;
            out_last  <= 1'b0;
            err       <= 1'b0;
            opc_q     <= 8'h00;
            opnd_q    <= 24'h0;
            n_q       <= 2'd0;
        end else begin
            err <= 1'b0;
            if (state == IDLE) begin
                in_ready <= 1'b1;
                if (accept) begin
                    if (bad) begin
                        err <= 1'b1;
                    end else begin
                        opc_q     <= lut_op;
                        opnd_q    <= operand;
                        n_q       <= len;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                        if (need_pfx) begin
                            state    <= PFX;
                            out_byte <= prefix_byte(rw, aw24);
                            out_last <= 1'b0;
                        end else begin
                            state    <= OPC;
                            out_byte <= lut_op;
                            out_last <= (len == 2'd0);
                        end
                    end
                end
            end else if (fire) begin
                // The byte flagged last closes the instruction.
                if (out_last) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    in_ready  <= 1'b1;
                end else begin
                    unique case (state)
                        PFX: begin
                            state    <= OPC;
                            out_byte <= opc_q;
                            out_last <= (n_q == 2'd0);
                        end
                        OPC: begin
                            state    <= OP0;
                            out_byte <= opnd_q[7:0];
                            out_last <= (n_q == 2'd1);
                        end
                        OP0: begin
                            state    <= OP1;
                            out_byte <= opnd_q[15:8];
                            out_last <= (n_q == 2'd2);
                        end
                        OP1: begin
                            state    <= OP2;
                            out_byte <= opnd_q[23:16];
                            out_last <= 1'b1;
                        end
                        default: begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            in_ready  <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_asm_encoder.sv
// Directed bench for asm_encoder: vector table plus stall and
// mid-instruction reset sequences.
import asm_pkg::*;

module tb_asm_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] mnem;
    logic [3:0]  mode_s;
    logic [23:0] operand;
    logic        aw24;
    logic [1:0]  rw;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic        out_last;
    logic        err;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    asm_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mnem      (mnem),
        .mode      (mode_s),
        .operand   (operand),
        .aw24      (aw24),
        .rw        (rw),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_byte  (out_byte),
        .out_last  (out_last),
        .err       (err)
    );

    typedef struct {
        logic [23:0]     mn;
        logic [3:0]      md;
        logic [23:0]     op;
        logic            aw;
        logic [1:0]      rw;
        logic            er;
        int              n;
        int              st;
        logic [4:0][7:0] b;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic vec_t mk(
        input logic [23:0] mn, input mode_t md, input logic [23:0] op,
        input logic aw, input logic [1:0] r, input logic er, input int n,
        input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
        input logic [7:0] b3, input logic [7:0] b4);
        vec_t v;
        v.mn = mn; v.md = md; v.op = op; v.aw = aw; v.rw = r;
        v.er = er; v.n = n; v.st = -1;
        v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3; v.b[4] = b4;
        return v;
    endfunction

    task automatic send(input vec_t v);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("in_ready before request", in_ready, 1);
        mnem = v.mn; mode_s = v.md; operand = v.op;
        aw24 = v.aw; rw = v.rw; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        // Scramble request fields: must not affect the accepted one.
        mnem = "XXX"; operand = ~v.op; aw24 = ~v.aw; rw = 2'd3;
    endtask

    task automatic run(input int id, input vec_t v);
        int cnt, cyc, stalled;
        bit done;
        send(v);
        if (v.er) begin
            chk($sformatf("v%0d err pulse", id), err, 1);
            chk($sformatf("v%0d no valid", id), out_valid, 0);
            @(negedge clk);
            chk($sformatf("v%0d err drop", id), err, 0);
            chk($sformatf("v%0d still no valid", id), out_valid, 0);
            chk($sformatf("v%0d in_ready", id), in_ready, 1);
            return;
        end
        chk($sformatf("v%0d latency", id), out_valid, 1);
        cnt = 0; cyc = 0; stalled = 0; done = 0;
        while (!done && cyc < 50) begin
            if (out_valid) begin
                if (cnt == v.st && stalled < 3) begin
                    out_ready = 1'b0;
                    if (stalled > 0)
                        chk($sformatf("v%0d hold", id), out_byte, v.b[cnt]);
                    stalled++;
                end else begin
                    out_ready = 1'b1;
                    chk($sformatf("v%0d byte%0d", id, cnt),
                        out_byte, v.b[cnt]);
                    chk($sformatf("v%0d last%0d", id, cnt),
                        out_last, (cnt == v.n - 1));
                    cnt++;
                    if (out_last || cnt >= v.n) done = 1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b1;
        chk($sformatf("v%0d count", id), cnt, v.n);
        chk($sformatf("v%0d bubble", id), out_valid, 0);
    endtask

    initial begin
        vecs[0]  = mk("NOP", IMP, 24'h0, 0, 0, 0, 1,
                      8'hEA, 0, 0, 0, 0);
        vecs[1]  = mk("LDA", IMM, 24'h000042, 0, 0, 0, 2,
                      8'hA9, 8'h42, 0, 0, 0);
        vecs[2]  = mk("STA", ABS, 24'h123456, 1, 0, 0, 5,
                      8'h1F, 8'h8D, 8'h56, 8'h34, 8'h12);
        vecs[3]  = mk("LDA", IMM, 24'hABCDEF, 1, 2, 0, 5,
                      8'h9F, 8'hA9, 8'hEF, 8'hCD, 8'hAB);
        vecs[3].st = 3;
        vecs[4]  = mk("XYZ", ABS, 24'h1234, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        vecs[5]  = mk("LDA", IMM, 24'h42, 0, 3, 1, 0, 0, 0, 0, 0, 0);
        vecs[6]  = mk("STA", IMM, 24'h42, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        vecs[7]  = mk("LDA", ZPI, 24'h20, 0, 0, 0, 2,
                      8'hB2, 8'h20, 0, 0, 0);
        vecs[8]  = mk("ROR", ABX, 24'h1234, 0, 0, 0, 3,
                      8'h7E, 8'h34, 8'h12, 0, 0);
        vecs[9]  = mk("LDA", IMM, 24'h1234, 0, 1, 0, 4,
                      8'h4F, 8'hA9, 8'h34, 8'h12, 0);
        vecs[10] = mk("JMP", AIX, 24'h1234, 0, 0, 0, 3,
                      8'h7C, 8'h34, 8'h12, 0, 0);
        vecs[11] = mk("LDX", ZPY, 24'h10, 0, 0, 0, 2,
                      8'hB6, 8'h10, 0, 0, 0);
        vecs[12] = mk("ASL", ACC, 24'h0, 0, 0, 0, 1,
                      8'h0A, 0, 0, 0, 0);
        vecs[13] = mk("JSR", ABS, 24'h0A0B0C, 1, 0, 0, 5,
                      8'h1F, 8'h20, 8'h0C, 8'h0B, 8'h0A);

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        mnem = "NOP"; mode_s = IMP; operand = '0; aw24 = 0; rw = 0;
        repeat (2) @(negedge clk);
        chk("reset in_ready", in_ready, 0);
        chk("reset out_valid", out_valid, 0);
        chk("reset out_byte", out_byte, 0);
        chk("reset out_last", out_last, 0);
        chk("reset err", err, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle in_ready", in_ready, 1);

        for (int i = 0; i < 14; i++) run(i, vecs[i]);

        // Reset during OP1 of JMP (abs) 0x1234: 6C, 34, 12.
        send(mk("JMP", IND, 24'h1234, 0, 0, 0, 3,
                8'h6C, 8'h34, 8'h12, 0, 0));
        chk("jmp byte0", out_byte, 8'h6C);
        @(negedge clk);
        chk("jmp byte1", out_byte, 8'h34);
        @(negedge clk);
        chk("jmp byte2", out_byte, 8'h12);
        rst_n = 1'b0;
        #1;
        chk("rst out_valid", out_valid, 0);
        chk("rst out_last", out_last, 0);
        chk("rst out_byte", out_byte, 0);
        chk("rst in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post-rst in_ready", in_ready, 1);
        run(100, mk("BRA", REL, 24'hFE, 0, 0, 0, 2,
                    8'h80, 8'hFE, 0, 0, 0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
